// File: rtl/cpu_pkg.sv
// Shared cpu/loader definitions: data width, memory depth, HLT fill value,
// loader state encoding and cpu opcodes.
package cpu_pkg;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 16;

    typedef logic [WIDTH-1:0] DEFAULT_TYPE;

    localparam DEFAULT_TYPE HLT_FILL = 8'hF0;

    typedef enum logic {
        LOAD,
        RUN
    } LOADER_STATE_TYPE;

    typedef enum logic [WIDTH-1:0] {
        HLT = 8'hF0
    } OPCODE_TYPE;

endpackage

// File: rtl/program_ram.sv
// Program memory: flop array with synchronous write, single-cycle clear to FILL
// and a zero-latency range-checked read port.
module program_ram
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = cpu_pkg::WIDTH,
    parameter int unsigned DEPTH = cpu_pkg::DEPTH,
    parameter logic [WIDTH-1:0] FILL = HLT_FILL,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             clear_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [WIDTH-1:0] raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    localparam logic [WIDTH:0] DepthW = (WIDTH + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= FILL;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Addresses past the end read as HLT so a runaway cpu stops.
    always_comb begin
        rdata_o = FILL;
        if ({1'b0, raddr_i} < DepthW) begin
            rdata_o = mem_q[raddr_i[AW-1:0]];
        end
    end

endmodule

// File: rtl/program_loader.sv
// Streams a program into program memory over valid/ready, holds the cpu in
// reset while loading and releases it once the last byte lands.
module program_loader
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = cpu_pkg::WIDTH,
    parameter int unsigned DEPTH = cpu_pkg::DEPTH,
    parameter logic [WIDTH-1:0] FILL = HLT_FILL,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH) + 1
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             LOAD_VALID,
    input  logic [WIDTH-1:0] LOAD_DATA,
    input  logic             LOAD_LAST,
    output logic             LOAD_READY,
    input  logic             RESTART,
    input  logic [WIDTH-1:0] ip,
    output logic [WIDTH-1:0] memory_ip,
    output logic             CPU_RESET,
    output logic [CW-1:0]    LOAD_COUNT
);

    localparam logic [CW-1:0] LastIdx = CW'(DEPTH - 1);

    LOADER_STATE_TYPE state_q;
    logic [CW-1:0]    count_q;
    logic             cpu_reset_q;
    logic             transfer;
    logic             last_byte;
    logic             clear;

    assign LOAD_READY = (state_q == LOAD);
    assign clear      = RESET | RESTART;
    // RESTART wins over a same-cycle transfer.
    assign transfer   = LOAD_VALID & LOAD_READY & ~RESTART;
    assign last_byte  = LOAD_LAST | (count_q == LastIdx);

    always_ff @(posedge CLOCK) begin
        if (clear) begin
            state_q     <= LOAD;
            count_q     <= '0;
            cpu_reset_q <= 1'b1;
        end else if (transfer) begin
            count_q <= count_q + 1'b1;
            if (last_byte) begin
                state_q     <= RUN;
                cpu_reset_q <= 1'b0;
            end
        end
    end

    assign CPU_RESET  = cpu_reset_q;
    assign LOAD_COUNT = count_q;

    program_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .FILL  (FILL)
    ) u_ram (
        .clk_i   (CLOCK),
        .clear_i (clear),
        .we_i    (transfer),
        .waddr_i (count_q[AW-1:0]),
        .wdata_i (LOAD_DATA),
        .raddr_i (ip),
        .rdata_o (memory_ip)
    );

endmodule
